// File: rtl/invert_pkg.sv
// Shared types and sizing helpers for the bit-serial two's-complement negator.
package invert_pkg;

    typedef enum logic {S_PASS, S_INV} invert_state_t;

    localparam int unsigned INVERT_CNT_W_MIN = 32'd1;

    // Word-counter width: $clog2 of the word length, never narrower than one bit.
    function automatic int unsigned invert_cnt_width(input int unsigned word_len);
        int unsigned w;
        w = $clog2(word_len);
        return (w < INVERT_CNT_W_MIN) ? INVERT_CNT_W_MIN : w;
    endfunction

endpackage

// File: rtl/invert_if.sv
// Serial data pair for the negator: operand bit in, result bit out.
interface invert_if;

    logic i;
    logic y;

    modport master (output i, input y);
    modport slave  (input i, output y);

endinterface

// File: rtl/invert.sv
// Bit-serial two's-complement negator, LSB first: pass bits through the first 1, invert after.
// Define INVERT_REG_OUT_EN to register y (one cycle latency) instead of the Mealy output.
module invert
    import invert_pkg::*;
#(
    parameter int unsigned WORD_LEN = 32'd0
) (
    input  logic i,
    input  logic r,
    input  logic t_clk,
    output logic y
);

    localparam int unsigned     CNT_W    = invert_cnt_width(WORD_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((WORD_LEN == 32'd0) ? 32'd0 : WORD_LEN - 32'd1);

    invert_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_d;

    // State and word-position registers; reset also restarts the word.
    always_ff @(posedge t_clk) begin
        if (r) begin
            state_q <= S_PASS;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Mealy output and next state; the word boundary overrides the first-one transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = 1'b0;
        if (r) begin
            state_d = S_PASS;
            cnt_d   = '0;
            y_d     = 1'b0;
        end else begin
            case (state_q)
                S_PASS: begin
                    y_d     = i;
                    state_d = i ? S_INV : S_PASS;
                end
                S_INV: begin
                    y_d     = ~i;
                    state_d = S_INV;
                end
                default: begin
                    y_d     = 1'b0;
                    state_d = S_PASS;
                end
            endcase
            if (WORD_LEN != 32'd0) begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = S_PASS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

`ifdef INVERT_REG_OUT_EN
    logic y_q;

    // Registered result: the Mealy value from the pre-edge state and sampled i.
    always_ff @(posedge t_clk) begin
        if (r) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;
`else
    assign y = y_d;
`endif

endmodule

// File: tb/tb_invert.sv
// Directed bench for invert: unbounded-word instance and a WORD_LEN=4 instance.
`timescale 1ns/100ps
module tb_invert;

    logic t_clk = 1'b0;
    logic r0;
    logic r4;
    int   checks = 0;
    int   errors = 0;

    invert_if if0 ();
    invert_if if4 ();

    invert #(.WORD_LEN(32'd0)) u_dut0 (.i(if0.i), .r(r0), .t_clk(t_clk), .y(if0.y));
    invert #(.WORD_LEN(32'd4)) u_dut4 (.i(if4.i), .r(r4), .t_clk(t_clk), .y(if4.y));

    always #10 t_clk = ~t_clk;

    task automatic check(input logic obs, input logic exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one bit on the unbounded instance at the falling edge and check y.
    task automatic step0(input logic iv, input logic rv, input logic exp, input string tag);
        @(negedge t_clk);
        if0.i = iv;
        r0    = rv;
        #1;
        check(if0.y, exp, tag);
    endtask

    task automatic step4(input logic iv, input logic rv, input logic exp, input string tag);
        @(negedge t_clk);
        if4.i = iv;
        r4    = rv;
        #1;
        check(if4.y, exp, tag);
    endtask

    initial begin
        r0    = 1'b1;
        r4    = 1'b1;
        if0.i = 1'b0;
        if4.i = 1'b0;

        // Reset with i toggling: y stays 0
        step0(1'b1, 1'b1, 1'b0, "rst_i1");
        #2 if0.i = 1'b0;
        #1 check(if0.y, 1'b0, "rst_i0");

        // 52 = 110100b, LSB first -> 12
        step0(1'b0, 1'b0, 1'b0, "w52_b0");
        step0(1'b0, 1'b0, 1'b0, "w52_b1");
        step0(1'b1, 1'b0, 1'b1, "w52_b2");
        step0(1'b0, 1'b0, 1'b1, "w52_b3");
        step0(1'b1, 1'b0, 1'b0, "w52_b4");
        step0(1'b1, 1'b0, 1'b0, "w52_b5");
        step0(1'b1, 1'b1, 1'b0, "w52_rst");

        // All zeros, then the first one passes and the next inverts
        for (int k = 0; k < 8; k++) begin
            step0(1'b0, 1'b0, 1'b0, $sformatf("zero_b%0d", k));
        end
        step0(1'b1, 1'b0, 1'b1, "zero_first1");
        step0(1'b1, 1'b0, 1'b0, "zero_next1");

        // Reset mid-word while in S_INV
        step0(1'b0, 1'b1, 1'b0, "mid_rst0");
        step0(1'b1, 1'b0, 1'b1, "mid_b0");
        step0(1'b0, 1'b0, 1'b1, "mid_b1");
        step0(1'b1, 1'b1, 1'b0, "mid_rst");
        step0(1'b0, 1'b0, 1'b0, "mid_n0");
        step0(1'b1, 1'b0, 1'b1, "mid_n1");
        step0(1'b1, 1'b0, 1'b0, "mid_n2");

        // Glitch between edges in S_PASS; only sampled 0 matters
        step0(1'b0, 1'b1, 1'b0, "gl_rst");
        step0(1'b0, 1'b0, 1'b0, "gl_lo");
        #1 if0.i = 1'b1;
        #1 check(if0.y, 1'b1, "gl_hi");
        #1 if0.i = 1'b0;
        #1 check(if0.y, 1'b0, "gl_back");
        step0(1'b1, 1'b0, 1'b1, "gl_after1");
        step0(1'b1, 1'b0, 1'b0, "gl_after2");

        // Most-negative 4-bit value maps to itself
        step0(1'b0, 1'b1, 1'b0, "mn_rst");
        step0(1'b0, 1'b0, 1'b0, "mn_b0");
        step0(1'b0, 1'b0, 1'b0, "mn_b1");
        step0(1'b0, 1'b0, 1'b0, "mn_b2");
        step0(1'b1, 1'b0, 1'b1, "mn_b3");
        step0(1'b0, 1'b1, 1'b0, "mn_idle");

        // WORD_LEN=4: words 1000 and 0100 back-to-back
        step4(1'b0, 1'b1, 1'b0, "wl_rst");
        step4(1'b1, 1'b0, 1'b1, "wl_a0");
        step4(1'b0, 1'b0, 1'b1, "wl_a1");
        step4(1'b0, 1'b0, 1'b1, "wl_a2");
        step4(1'b0, 1'b0, 1'b1, "wl_a3");
        step4(1'b0, 1'b0, 1'b0, "wl_b0");
        step4(1'b1, 1'b0, 1'b1, "wl_b1");
        step4(1'b0, 1'b0, 1'b1, "wl_b2");
        step4(1'b0, 1'b0, 1'b1, "wl_b3");

        // Reset mid-word clears the word counter
        step4(1'b0, 1'b0, 1'b0, "wl_c0");
        step4(1'b1, 1'b0, 1'b1, "wl_c1");
        step4(1'b1, 1'b1, 1'b0, "wl_crst");
        step4(1'b0, 1'b0, 1'b0, "wl_d0");
        step4(1'b0, 1'b0, 1'b0, "wl_d1");
        step4(1'b0, 1'b0, 1'b0, "wl_d2");
        step4(1'b1, 1'b0, 1'b1, "wl_d3");
        step4(1'b1, 1'b0, 1'b1, "wl_e0");
        step4(1'b1, 1'b0, 1'b0, "wl_e1");

        @(negedge t_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/invert.md
Name: invert

Overview:
- Bit-serial two's-complement negator; operand bits arrive LSB first, one per clock on `i`.
- Output `y` carries the negated value bit-serially, same bit order.
- Rule: pass bits unchanged up to and including the first 1, then invert every later bit.
- Used as a streaming negation stage in serial arithmetic datapaths; reset marks the start of a new word.

Parameters:
- WORD_LEN, 0, bits per word. 0 means unbounded: only `r` restarts a word. N>0 means automatic restart after every N sampled bits.

Ports:
- t_clk  input  1  clock; all state changes on rising edge.
- r      input  1  synchronous active-high reset; also word restart.
- i      input  1  serial operand bit, LSB first.
- y      output 1  serial two's-complement result bit.
- Declaration order is fixed as (i, r, t_clk, y) for positional instantiation.

Behaviour:
- State register `seen_one` has two states, S_PASS and S_INV; reset state is S_PASS.
- Output (Mealy, combinational):
  - r=1: y=0.
  - S_PASS: y=i.
  - S_INV: y=~i.
  - Zero latency: y follows i within the same cycle.
- Transitions at rising t_clk:
  - r=1: go to S_PASS and clear the bit counter; i is ignored.
  - S_PASS with i=1: go to S_INV. This 1 is itself passed uninverted.
  - S_PASS with i=0: stay in S_PASS.
  - S_INV: stay in S_INV regardless of i.
- Word boundary (WORD_LEN>0):
  - Counter 0..WORD_LEN-1 increments on each non-reset edge.
  - On the edge where counter = WORD_LEN-1: counter goes to 0 and state goes to S_PASS, overriding the i=1 transition.
  - The next bit is treated as a new LSB.
- Reset has priority over the word boundary.
- Reset mid-word discards the partial word; the next edge after r falls samples a fresh LSB.
- All-zero word: output is all zeros; state never leaves S_PASS.
- Most-negative value (MSB-only 1) maps to itself; no overflow flag.
- i changes between clock edges propagate to y combinationally. Only the value present at the rising edge affects state.
- No X on y once r has been sampled high at least once.

Optional Feature:
- Macro INVERT_REG_OUT_EN.
- Defined:
  - y is a flop updated at rising t_clk with the Mealy value computed from pre-edge state and sampled i.
  - One-cycle latency; y=0 during and on the edge of reset.
- Undefined:
  - Purely combinational Mealy output as specified above.

Decomposition:
- Package invert_pkg holds:
  - typedef enum logic {S_PASS, S_INV} invert_state_t.
  - Localparam for the counter width: $clog2(WORD_LEN) with a minimum of 1.
- No sub-module needed; the single always_ff and output assign are in one module.

Test Plan:
1. Reset: r=1 for one edge, i toggling -> y=0 throughout; state S_PASS after the edge.
2. Word 52, LSB-first 0,0,1,0,1,1, WORD_LEN=0 -> y = 0,0,1,1,0,0 (value 12, i.e. -52 mod 64).
3. All zeros for 8 bits -> y=0 every bit; then i=1 -> y=1, and the following i=1 -> y=0.
4. Reset mid-word: after bits 1,0 (now S_INV), pulse r, then send 0,1,1 -> y = 0,1,0.
5. Mid-cycle glitch: in S_PASS, i goes 0→1→0 between edges -> y mirrors i; state unchanged at the next edge (sampled i=0).
6. WORD_LEN=4, words 1000 then 0100 back-to-back, LSB-first (1,0,0,0,0,1,0,0) -> y = 1,1,1,1,0,1,1,1. The second word starts in S_PASS.
